// File: rtl/wb_trace_checker.sv
// wb_trace_checker
//   Watches the CPU register-file write-back port and compares each
//   architectural write against a preloaded expected-trace table, ending the
//   run with a registered PASS / FAIL / timeout verdict.
//
//   Ports
//     clk, rst          rising-edge clock, asynchronous active-low reset
//     exp_we_i/addr/wd/wdata   table load port (accepted in IDLE only)
//     exp_len_i         entries to check, sampled with start_i (clipped to DEPTH)
//     start_i           begin checking (ignored if exp_we_i is high that cycle)
//     clear_i           leave PASS/FAIL back to IDLE
//     wreg_i/wd_i/wdata_i      core write-back port being observed
//     busy_o/pass_o/fail_o     state flags (RUN / PASS / FAIL)
//     timeout_o         FAIL was caused by inactivity
//     match_cnt_o       entries matched so far
//     fail_wd_o/fail_wdata_o   write-back captured at the mismatch
module wb_trace_checker #(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int TIMEOUT   = 200,
    parameter int IGNORE_R0 = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exp_we_i,
    input  logic [ADDR_W-1:0] exp_addr_i,
    input  logic [4:0]        exp_wd_i,
    input  logic [31:0]       exp_wdata_i,
    input  logic [ADDR_W:0]   exp_len_i,
    input  logic              start_i,
    input  logic              clear_i,
    input  logic              wreg_i,
    input  logic [4:0]        wd_i,
    input  logic [31:0]       wdata_i,
    output logic              busy_o,
    output logic              pass_o,
    output logic              fail_o,
    output logic              timeout_o,
    output logic [ADDR_W:0]   match_cnt_o,
    output logic [4:0]        fail_wd_o,
    output logic [31:0]       fail_wdata_o
);

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0]   TMAX    = TW'(TIMEOUT - 1);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   match_cnt_q, match_cnt_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [4:0]        fail_wd_q, fail_wd_d;
    logic [31:0]       fail_wdata_q, fail_wdata_d;
    logic              timeout_q, timeout_d;
    logic              busy_q, busy_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;

    // Expected trace table. The entry under test is read one cycle ahead
    // (address idx_d), so exp_entry_q always holds entry[idx_q] while in RUN.
    logic [36:0] mem [DEPTH];
    logic [36:0] exp_entry_q;
    logic        mem_we;

    assign mem_we = exp_we_i && (state_q == S_IDLE);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[exp_addr_i] <= {exp_wd_i, exp_wdata_i};
        end
        exp_entry_q <= mem[idx_d];
    end

    logic            qualify;
    logic            match;
    logic            last;
    logic [ADDR_W:0] len_clip;

    assign qualify  = wreg_i && !((IGNORE_R0 != 0) && (wd_i == 5'd0));
    assign match    = ({wd_i, wdata_i} == exp_entry_q);
    assign last     = (({1'b0, idx_q} + 1'b1) == len_q);
    assign len_clip = (exp_len_i > DEPTH_L) ? DEPTH_L : exp_len_i;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        len_d        = len_q;
        match_cnt_d  = match_cnt_q;
        timer_d      = timer_q;
        fail_wd_d    = fail_wd_q;
        fail_wdata_d = fail_wdata_q;
        timeout_d    = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !exp_we_i) begin
                    len_d       = len_clip;
                    idx_d       = '0;
                    match_cnt_d = '0;
                    timer_d     = '0;
                    state_d     = (len_clip == '0) ? S_PASS : S_RUN;
                end
            end
            S_RUN: begin
                if (qualify) begin
                    if (match) begin
                        idx_d       = idx_q + 1'b1;
                        match_cnt_d = match_cnt_q + 1'b1;
                        timer_d     = '0;
                        if (last) begin
                            state_d = S_PASS;
                        end
                    end else begin
                        fail_wd_d    = wd_i;
                        fail_wdata_d = wdata_i;
                        state_d      = S_FAIL;
                    end
                end else if (timer_q == TMAX) begin
                    timeout_d = 1'b1;
                    state_d   = S_FAIL;
                end else if (timer_q != '1) begin
                    // Saturating: never wraps back to zero.
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                if (clear_i) begin
                    state_d      = S_IDLE;
                    match_cnt_d  = '0;
                    timeout_d    = 1'b0;
                    fail_wd_d    = '0;
                    fail_wdata_d = '0;
                end
            end
        endcase
        busy_d = (state_d == S_RUN);
        pass_d = (state_d == S_PASS);
        fail_d = (state_d == S_FAIL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            len_q        <= '0;
            match_cnt_q  <= '0;
            timer_q      <= '0;
            fail_wd_q    <= '0;
            fail_wdata_q <= '0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            match_cnt_q  <= match_cnt_d;
            timer_q      <= timer_d;
            fail_wd_q    <= fail_wd_d;
            fail_wdata_q <= fail_wdata_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
        end
    end

    assign busy_o       = busy_q;
    assign pass_o       = pass_q;
    assign fail_o       = fail_q;
    assign timeout_o    = timeout_q;
    assign match_cnt_o  = match_cnt_q;
    assign fail_wd_o    = fail_wd_q;
    assign fail_wdata_o = fail_wdata_q;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Scoreboard bench for wb_trace_checker. Instance A (TIMEOUT=8, IGNORE_R0=1)
// carries most scenarios; instance B (IGNORE_R0=0) only runs when b_en is set.
// Expected verdicts are queued as stimulus is issued; a negedge monitor pops
// and compares one entry each time a DUT raises pass_o or fail_o.
module tb_wb_trace_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        exp_we;
    logic [3:0]  exp_addr;
    logic [4:0]  exp_wd;
    logic [31:0] exp_wdata;
    logic [4:0]  exp_len;
    logic        start, clear, wreg;
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic        b_en;

    logic        a_busy, a_pass, a_fail, a_to;
    logic [4:0]  a_mc, a_fwd;
    logic [31:0] a_fwdata;
    logic        b_busy, b_pass, b_fail, b_to;
    logic [4:0]  b_mc, b_fwd;
    logic [31:0] b_fwdata;

    always #5 clk = ~clk;

    wb_trace_checker #(.DEPTH(16), .ADDR_W(4), .TIMEOUT(8), .IGNORE_R0(1)) dut_a (
        .clk(clk), .rst(rst),
        .exp_we_i(exp_we), .exp_addr_i(exp_addr), .exp_wd_i(exp_wd),
        .exp_wdata_i(exp_wdata), .exp_len_i(exp_len),
        .start_i(start), .clear_i(clear),
        .wreg_i(wreg), .wd_i(wd), .wdata_i(wdata),
        .busy_o(a_busy), .pass_o(a_pass), .fail_o(a_fail), .timeout_o(a_to),
        .match_cnt_o(a_mc), .fail_wd_o(a_fwd), .fail_wdata_o(a_fwdata)
    );

    wb_trace_checker #(.DEPTH(16), .ADDR_W(4), .TIMEOUT(200), .IGNORE_R0(0)) dut_b (
        .clk(clk), .rst(rst),
        .exp_we_i(exp_we), .exp_addr_i(exp_addr), .exp_wd_i(exp_wd),
        .exp_wdata_i(exp_wdata), .exp_len_i(exp_len),
        .start_i(start && b_en), .clear_i(clear),
        .wreg_i(wreg && b_en), .wd_i(wd), .wdata_i(wdata),
        .busy_o(b_busy), .pass_o(b_pass), .fail_o(b_fail), .timeout_o(b_to),
        .match_cnt_o(b_mc), .fail_wd_o(b_fwd), .fail_wdata_o(b_fwdata)
    );

    typedef struct {
        string       nm;
        logic        p;
        logic        f;
        logic        t;
        logic [4:0]  mc;
        logic [4:0]  fwd;
        logic [31:0] fwdata;
        int          cyc;   // -1: verdict cycle not checked
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   a_prev   = 1'b0;
    bit   b_prev   = 1'b0;
    bit   a_busy_seen = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input bit to_b, input string nm, input bit p, input bit f, input bit t,
                        input int mc, input int fwd, input logic [31:0] fwdata, input int c);
        exp_t e;
        e.nm = nm; e.p = p; e.f = f; e.t = t;
        e.mc = 5'(mc); e.fwd = 5'(fwd); e.fwdata = fwdata; e.cyc = c;
        if (to_b) qb.push_back(e);
        else      qa.push_back(e);
    endtask

    task automatic score(input bit is_b, input logic p, input logic f, input logic t,
                         input logic [4:0] mc, input logic [4:0] fwd, input logic [31:0] fwdata);
        exp_t e;
        string tag;
        tag = is_b ? "B" : "A";
        if ((is_b ? qb.size() : qa.size()) == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s unexpected verdict: got pass=%0b fail=%0b, expected none", tag, p, f);
            return;
        end
        e = is_b ? qb.pop_front() : qa.pop_front();
        $display("verdict %s %s: pass=%0b fail=%0b to=%0b cnt=%0d wd=%0d wdata=%08h cyc=%0d",
                 tag, e.nm, p, f, t, mc, fwd, fwdata, cyc);
        check({tag, " ", e.nm, " pass"},    64'(p),      64'(e.p));
        check({tag, " ", e.nm, " fail"},    64'(f),      64'(e.f));
        check({tag, " ", e.nm, " timeout"}, 64'(t),      64'(e.t));
        check({tag, " ", e.nm, " match"},   64'(mc),     64'(e.mc));
        check({tag, " ", e.nm, " fail_wd"}, 64'(fwd),    64'(e.fwd));
        check({tag, " ", e.nm, " fail_wdata"}, 64'(fwdata), 64'(e.fwdata));
        if (e.cyc >= 0) check({tag, " ", e.nm, " cycle"}, 64'(cyc), 64'(e.cyc));
    endtask

    // Monitor: one scoreboard pop per rising verdict on each DUT.
    always @(negedge clk) begin
        if (a_busy) a_busy_seen = 1'b1;
        if ((a_pass || a_fail) && !a_prev) score(1'b0, a_pass, a_fail, a_to, a_mc, a_fwd, a_fwdata);
        if ((b_pass || b_fail) && !b_prev) score(1'b1, b_pass, b_fail, b_to, b_mc, b_fwd, b_fwdata);
        a_prev = a_pass || a_fail;
        b_prev = b_pass || b_fail;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input int r, input logic [31:0] d);
        exp_we = 1'b1; exp_addr = 4'(a); exp_wd = 5'(r); exp_wdata = d;
        tick();
        exp_we = 1'b0;
    endtask

    task automatic do_start(input int len);
        exp_len = 5'(len); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic core_wr(input int r, input logic [31:0] d);
        wreg = 1'b1; wd = 5'(r); wdata = d;
        tick();
        wreg = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Bounded wait for a verdict on A (sel=0) or B (sel=1).
    task automatic wait_verdict(input bit sel, input int budget, input string nm);
        int i;
        for (i = 0; i < budget; i++) begin
            if (sel ? (b_pass || b_fail) : (a_pass || a_fail)) break;
            @(negedge clk);
        end
        if (i == budget) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s wait: got no verdict, expected one within %0d cycles", nm, budget);
        end
        tick();
    endtask

    task automatic load_trace();
        load(0, 1, 32'h0000_1100);
        load(1, 2, 32'h0000_0020);
        load(2, 3, 32'h0000_1120);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, " busy"},    64'(a_busy),   64'(0));
        check({nm, " pass"},    64'(a_pass),   64'(0));
        check({nm, " fail"},    64'(a_fail),   64'(0));
        check({nm, " timeout"}, 64'(a_to),     64'(0));
        check({nm, " match"},   64'(a_mc),     64'(0));
        check({nm, " fwd"},     64'(a_fwd),    64'(0));
        check({nm, " fwdata"},  64'(a_fwdata), 64'(0));
    endtask

    initial begin
        rst = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wd = '0; exp_wdata = '0;
        exp_len = '0; start = 1'b0; clear = 1'b0; wreg = 1'b0; wd = '0; wdata = '0;
        b_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        // 1: clean three-entry pass; pass_o appears the cycle after the last write
        load_trace();
        push(0, "t1_pass", 1, 0, 0, 3, 0, 32'h0, cyc + 4);
        do_start(3);
        core_wr(1, 32'h0000_1100);
        core_wr(2, 32'h0000_0020);
        core_wr(3, 32'h0000_1120);
        wait_verdict(0, 10, "t1");
        do_clear();

        // 2: data mismatch on the second entry
        push(0, "t2_mismatch", 0, 1, 0, 1, 2, 32'h0000_0021, -1);
        do_start(3);
        core_wr(1, 32'h0000_1100);
        core_wr(2, 32'h0000_0021);
        wait_verdict(0, 10, "t2");
        do_clear();

        // 3: r0 write interleaved; ignored by A, checked (and failing) on B
        b_en = 1'b1;
        push(0, "t3_ign_r0", 1, 0, 0, 3, 0, 32'h0, -1);
        push(1, "t3_chk_r0", 0, 1, 0, 1, 0, 32'hFFFF_FFFF, -1);
        do_start(3);
        core_wr(1, 32'h0000_1100);
        core_wr(0, 32'hFFFF_FFFF);
        core_wr(2, 32'h0000_0020);
        core_wr(3, 32'h0000_1120);
        wait_verdict(0, 10, "t3a");
        wait_verdict(1, 10, "t3b");
        do_clear();
        b_en = 1'b0;

        // 4: timeout fires exactly 8 cycles after the matched write
        do_start(2);
        push(0, "t4_timeout", 0, 1, 1, 1, 0, 32'h0, cyc + 9);
        core_wr(1, 32'h0000_1100);
        wait_verdict(0, 20, "t4");
        do_clear();

        // 5a: zero-length run passes next cycle without entering RUN
        a_busy_seen = 1'b0;
        push(0, "t5_len0", 1, 0, 0, 0, 0, 32'h0, cyc + 1);
        do_start(0);
        wait_verdict(0, 5, "t5a");
        check("t5 busy_never", 64'(a_busy_seen), 64'(0));
        do_clear();

        // 5b: length 31 is clipped to DEPTH=16
        for (int i = 0; i < 16; i++) load(i, i + 1, 32'hA500_0000 + 32'(i));
        push(0, "t5_clip", 1, 0, 0, 16, 0, 32'h0, -1);
        do_start(31);
        for (int i = 0; i < 16; i++) core_wr(i + 1, 32'hA500_0000 + 32'(i));
        wait_verdict(0, 20, "t5b");
        do_clear();

        // 6: asynchronous reset mid-RUN, then rerun without reloading
        load_trace();
        do_start(3);
        core_wr(1, 32'h0000_1100);
        check("t6 busy_pre", 64'(a_busy), 64'(1));
        check("t6 match_pre", 64'(a_mc), 64'(1));
        #1 rst = 1'b0;
        #1;
        check_all_zero("t6 async_rst");
        #1 rst = 1'b1;
        tick();
        push(0, "t6_rerun", 1, 0, 0, 3, 0, 32'h0, -1);
        do_start(3);
        core_wr(1, 32'h0000_1100);
        core_wr(2, 32'h0000_0020);
        core_wr(3, 32'h0000_1120);
        wait_verdict(0, 10, "t6a");
        do_clear();

        // 6b: clear out of FAIL returns every output to zero
        push(0, "t6_fail", 0, 1, 0, 0, 1, 32'h0000_1101, -1);
        do_start(3);
        core_wr(1, 32'h0000_1101);
        wait_verdict(0, 10, "t6b");
        do_clear();
        check_all_zero("t6 clear");

        tick();
        check("qa_drained", 64'(qa.size()), 64'(0));
        check("qb_drained", 64'(qb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
